// File: rtl/cnn_pool_unit_pkg.sv
// Shared definitions for the multi-lane pooling engine: mode codes, config FSM
// states and elaboration-time helpers for the reciprocal table and tree sizing.
package cnn_pool_unit_pkg;

  typedef enum logic [1:0] {
    POOL_MIN = 2'd0,
    POOL_MAX = 2'd1,
    POOL_AVG = 2'd2
  } pool_mode_e;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

  // round(2^recip_w / n), evaluated only on constants
  function automatic int pool_recip(input int n, input int recip_w);
    return ((1 << recip_w) + n / 2) / n;
  endfunction

  // number of live nodes at tree level k
  function automatic int lvl_size(input int win, input int k);
    return (win + (1 << k) - 1) >> k;
  endfunction

  function automatic pool_mode_e norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? POOL_MAX : pool_mode_e'(m);
  endfunction

endpackage

// File: rtl/cnn_pool_unit_combine.sv
// One reduction-tree node: min, max or add of two signed operands.
module cnn_pool_unit_combine
  import cnn_pool_unit_pkg::*;
#(
  parameter int DATA_W = 36
) (
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);

  always_comb begin
    case (mode)
      POOL_MIN: y = (a < b) ? a : b;
      POOL_AVG: y = a + b;
      default:  y = (a > b) ? a : b;
    endcase
  end

endmodule

// File: rtl/cnn_pool_unit.sv
// Multi-lane min/max/avg pooling engine with valid/ready flow and a registered
// reduction tree. Define POOL_RELU_EN to clamp negative lane results to zero.
module cnn_pool_unit
  import cnn_pool_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LANES   = 4,
  parameter int MAX_K   = 3,
  parameter int RECIP_W = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                conf_refresh,
  input  logic [$clog2(MAX_K+1)-1:0]          kernel_h,
  input  logic [$clog2(MAX_K+1)-1:0]          kernel_w,
  input  logic [1:0]                          pool_mode,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*MAX_K*MAX_K*DATA_W-1:0] in_window,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*DATA_W-1:0]             out_data,
  output logic                                pool_empty
);

  localparam int WIN    = MAX_K * MAX_K;
  localparam int TS     = $clog2(WIN);
  localparam int KW     = $clog2(MAX_K + 1);
  localparam int NW     = $clog2(WIN + 1);
  localparam int SUM_W  = DATA_W + TS;
  localparam int PROD_W = SUM_W + RECIP_W + 2;

  localparam logic signed [SUM_W-1:0]  ID_MAX = {{(TS+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]  ID_MIN = {{(TS+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] P_MAX  = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] P_MIN  = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] RND    = {{(PROD_W-RECIP_W){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};

  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    return (k == '0 || k > KW'(MAX_K)) ? KW'(MAX_K) : k;
  endfunction

  function automatic logic signed [SUM_W-1:0] identity(input pool_mode_e m);
    case (m)
      POOL_MIN: return ID_MAX;
      POOL_AVG: return '0;
      default:  return ID_MIN;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] avg_sat(input logic signed [SUM_W-1:0] s,
                                                       input logic [RECIP_W:0] r);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(s) * $signed(PROD_W'(r));
    p = (p + RND) >>> RECIP_W;
    if (p > P_MAX)      return P_MAX[DATA_W-1:0];
    else if (p < P_MIN) return P_MIN[DATA_W-1:0];
    else                return p[DATA_W-1:0];
  endfunction

  cfg_state_e state;
  logic [KW-1:0] cfg_h, cfg_w, pend_h, pend_w;
  pool_mode_e    cfg_mode, pend_mode;

  logic [TS:0]              vld_p;
  logic signed [SUM_W-1:0]  lvl_p [TS+1][LANES][WIN];
  logic signed [SUM_W-1:0]  lvl_d [1:TS][LANES][WIN];
  logic signed [SUM_W-1:0]  mask_d [LANES][WIN];
  pool_mode_e               mode_p [TS+1];
  logic [NW-1:0]            n_p [TS+1];
  logic [LANES*DATA_W-1:0]  post_d;
  logic [RECIP_W:0]         recip_tab [WIN+1];

  logic adv, accept, busy, last_leave;

  assign adv        = ~out_valid | out_ready;
  assign in_ready   = adv & (state == CFG_IDLE);
  assign accept     = in_valid & in_ready;
  assign busy       = (|vld_p) | out_valid;
  assign last_leave = out_valid & out_ready & ~(|vld_p);
  assign pool_empty = ~busy & (state == CFG_IDLE);

  // A refresh while beats are in flight is shadowed until the pipe drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CFG_IDLE;
      cfg_h     <= KW'(1);
      cfg_w     <= KW'(1);
      cfg_mode  <= POOL_MAX;
      pend_h    <= KW'(1);
      pend_w    <= KW'(1);
      pend_mode <= POOL_MAX;
    end else begin
      case (state)
        CFG_IDLE: begin
          if (conf_refresh) begin
            if (busy && !last_leave) begin
              state     <= CFG_PEND;
              pend_h    <= clamp_k(kernel_h);
              pend_w    <= clamp_k(kernel_w);
              pend_mode <= norm_mode(pool_mode);
            end else begin
              cfg_h    <= clamp_k(kernel_h);
              cfg_w    <= clamp_k(kernel_w);
              cfg_mode <= norm_mode(pool_mode);
            end
          end
        end
        default: begin
          if (conf_refresh) begin
            pend_h    <= clamp_k(kernel_h);
            pend_w    <= clamp_k(kernel_w);
            pend_mode <= norm_mode(pool_mode);
          end
          if (last_leave || !busy) begin
            state    <= CFG_IDLE;
            cfg_h    <= conf_refresh ? clamp_k(kernel_h) : pend_h;
            cfg_w    <= conf_refresh ? clamp_k(kernel_w) : pend_w;
            cfg_mode <= conf_refresh ? norm_mode(pool_mode) : pend_mode;
          end
        end
      endcase
    end
  end

  // Stage 0: replace out-of-kernel elements by the mode identity
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int r = 0; r < MAX_K; r++) begin
        for (int c = 0; c < MAX_K; c++) begin
          logic signed [DATA_W-1:0] elem;
          elem = in_window[(l*WIN + r*MAX_K + c)*DATA_W +: DATA_W];
          mask_d[l][r*MAX_K+c] = (KW'(r) < cfg_h && KW'(c) < cfg_w) ? SUM_W'(elem)
                                                                   : identity(cfg_mode);
        end
      end
    end
  end

  for (genvar i = 0; i <= WIN; i++) begin : g_recip
    if (i == 0) begin : g_nil
      assign recip_tab[i] = '0;
    end else begin : g_val
      localparam int RV = pool_recip(i, RECIP_W);
      assign recip_tab[i] = (RECIP_W+1)'(RV);
    end
  end

  // Stages 1..TS: pairwise reduction, odd node passes through
  for (genvar k = 1; k <= TS; k++) begin : g_lvl
    localparam int NPREV = lvl_size(WIN, k-1);
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      for (genvar j = 0; j < WIN; j++) begin : g_node
        if (2*j+1 < NPREV) begin : g_comb
          cnn_pool_unit_combine #(.DATA_W(SUM_W)) u_comb (
            .mode (mode_p[k-1]),
            .a    (lvl_p[k-1][l][2*j]),
            .b    (lvl_p[k-1][l][2*j+1]),
            .y    (lvl_d[k][l][j])
          );
        end else if (2*j < NPREV) begin : g_pass
          assign lvl_d[k][l][j] = lvl_p[k-1][l][2*j];
        end else begin : g_zero
          assign lvl_d[k][l][j] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lvl_p[0]  <= mask_d;
      mode_p[0] <= cfg_mode;
      n_p[0]    <= NW'(cfg_h) * NW'(cfg_w);
    end
    for (int k = 1; k <= TS; k++) begin
      if (adv && vld_p[k-1]) begin
        lvl_p[k]  <= lvl_d[k];
        mode_p[k] <= mode_p[k-1];
        n_p[k]    <= n_p[k-1];
      end
    end
  end

  // Post stage: average scaling, saturation and optional rectification
  always_comb begin
    post_d = '0;
    for (int l = 0; l < LANES; l++) begin
      logic signed [DATA_W-1:0] res;
      if (mode_p[TS] == POOL_AVG) res = avg_sat(lvl_p[TS][l][0], recip_tab[n_p[TS]]);
      else                        res = lvl_p[TS][l][0][DATA_W-1:0];
`ifdef POOL_RELU_EN
      if (res[DATA_W-1]) res = '0;
`endif
      post_d[l*DATA_W +: DATA_W] = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      vld_p     <= {vld_p[TS-1:0], accept};
      out_valid <= vld_p[TS];
      if (vld_p[TS]) out_data <= post_d;
    end
  end

endmodule
